// File: rtl/cordic_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_sched : round-robin scheduler sharing one pipelined CORDIC sin/cos core
// Revision     : 1.0
// ---------------------------------------------------------------------------
module cordic_sched #(
  parameter int N_REQ     = 4,
  parameter int BITS_HIGH = 16,
  parameter int BITS_LOW  = 16,
  parameter int LAT       = BITS_HIGH + BITS_LOW,
  parameter int MAX_OUT   = 8,
  localparam int W   = BITS_HIGH + BITS_LOW,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int IFW = $clog2(LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [W-1:0]       res_sin,
  output logic [W-1:0]       res_cos,
  output logic [IFW-1:0]     inflight,
  output logic               busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int G  = 8;               // guard bits carried through the core
  localparam int FB = BITS_LOW + G;
  localparam int SH = 30 - FB;
  localparam int XW = FB + 3;
  localparam int ZW = W + G + 1;

  localparam logic signed [63:0]   PI_Q30 = 64'sd3373259426;
  localparam logic signed [63:0]   K_Q30  = 64'sd652032874;
  localparam logic signed [ZW-1:0] Z_PI   = ZW'(PI_Q30 >>> SH);
  localparam logic signed [ZW-1:0] Z_PIH  = ZW'(PI_Q30 >>> (SH + 1));
  localparam logic signed [XW-1:0] X_K    = XW'(K_Q30 >>> SH);
  localparam logic signed [XW-1:0] X_RND  = XW'(1) <<< (G - 1);

  // atan(2^-i) scaled by 2^30; beyond i=9 the small-angle value 2^-i is exact enough
  function automatic logic signed [63:0] atan_q30(input int i);
    case (i)
      0:       return 64'sd843314857;
      1:       return 64'sd497837829;
      2:       return 64'sd263043837;
      3:       return 64'sd133525159;
      4:       return 64'sd67021687;
      5:       return 64'sd33543516;
      6:       return 64'sd16775851;
      7:       return 64'sd8388437;
      8:       return 64'sd4194283;
      9:       return 64'sd2097149;
      default: return (i <= 30) ? (64'sd1 <<< (30 - i)) : 64'sd0;
    endcase
  endfunction

  logic [N_REQ-1:0]     w_elig;
  logic                 w_xfer;
  logic [IDW-1:0]       w_gnt_id;
  logic [N_REQ-1:0]     w_inc;
  logic [N_REQ-1:0]     w_dec;
  logic                 w_ret;
  logic [IDW-1:0]       r_rr;
  logic [CW-1:0]        r_cnt    [N_REQ];
  logic                 r_tag_v  [LAT];
  logic [IDW-1:0]       r_tag_id [LAT];
  logic [IFW-1:0]       r_inflight;

  logic signed [W-1:0]  w_core_x;
  logic signed [ZW-1:0] w_zin;
  logic signed [ZW-1:0] w_fz;
  logic                 w_fneg;
  logic signed [XW-1:0] r_cx   [LAT];
  logic signed [XW-1:0] r_cy   [LAT];
  logic signed [ZW-1:0] r_cz   [LAT];
  logic                 r_cneg [LAT];
  logic signed [XW-1:0] w_xo;
  logic signed [XW-1:0] w_yo;

  always_comb begin
    int idx;
    idx      = 0;
    w_xfer   = 1'b0;
    w_gnt_id = '0;
    for (int i = 0; i < N_REQ; i++)
      w_elig[i] = req_valid[i] && (r_cnt[i] < CW'(MAX_OUT)) && !rst;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_xfer && w_elig[idx]) begin
        w_xfer   = 1'b1;
        w_gnt_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt_id] = 1'b1;
  end

  assign w_ret = r_tag_v[LAT-1];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_inc[i] = w_xfer && (int'(w_gnt_id) == i);
      w_dec[i] = w_ret && (int'(r_tag_id[LAT-1]) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr       <= '0;
      r_inflight <= '0;
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_tag_v[k]  <= 1'b0;
        r_tag_id[k] <= '0;
      end
    end else begin
      if (w_xfer)
        r_rr <= (int'(w_gnt_id) == N_REQ - 1) ? '0 : w_gnt_id + 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      if (w_xfer && !w_ret)      r_inflight <= r_inflight + 1'b1;
      else if (w_ret && !w_xfer) r_inflight <= r_inflight - 1'b1;
      r_tag_v[0]  <= w_xfer;
      r_tag_id[0] <= w_gnt_id;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign w_core_x = w_xfer ? req_x[int'(w_gnt_id)*W +: W] : '0;

  // Fold |x| > pi/2 into [-pi/2, pi/2] by a half-turn; valid input range is [-3pi/2, 3pi/2]
  always_comb begin
    w_zin  = ZW'(w_core_x) <<< G;
    w_fz   = w_zin;
    w_fneg = 1'b0;
    if (w_zin > Z_PIH) begin
      w_fz   = w_zin - Z_PI;
      w_fneg = 1'b1;
    end else if (w_zin < -Z_PIH) begin
      w_fz   = w_zin + Z_PI;
      w_fneg = 1'b1;
    end
  end

  // Datapath carries no reset; stale contents are masked by the tag valid bits
  always_ff @(posedge clk) begin
    r_cx[0]   <= X_K;
    r_cy[0]   <= '0;
    r_cz[0]   <= w_fz;
    r_cneg[0] <= w_fneg;
    for (int k = 1; k < LAT; k++) begin
      if (!r_cz[k-1][ZW-1]) begin
        r_cx[k] <= r_cx[k-1] - (r_cy[k-1] >>> (k - 1));
        r_cy[k] <= r_cy[k-1] + (r_cx[k-1] >>> (k - 1));
        r_cz[k] <= r_cz[k-1] - ZW'(atan_q30(k - 1) >>> SH);
      end else begin
        r_cx[k] <= r_cx[k-1] + (r_cy[k-1] >>> (k - 1));
        r_cy[k] <= r_cy[k-1] - (r_cx[k-1] >>> (k - 1));
        r_cz[k] <= r_cz[k-1] + ZW'(atan_q30(k - 1) >>> SH);
      end
      r_cneg[k] <= r_cneg[k-1];
    end
  end

  assign w_xo = (r_cneg[LAT-1] ? -r_cx[LAT-1] : r_cx[LAT-1]) + X_RND;
  assign w_yo = (r_cneg[LAT-1] ? -r_cy[LAT-1] : r_cy[LAT-1]) + X_RND;

  assign res_valid = r_tag_v[LAT-1];
  assign res_id    = r_tag_id[LAT-1];
  assign res_sin   = res_valid ? W'(w_yo >>> G) : '0;
  assign res_cos   = res_valid ? W'(w_xo >>> G) : '0;
  assign inflight  = r_inflight;
  assign busy      = (r_inflight != '0);

endmodule
`default_nettype wire

// File: tb/tb_cordic_sched.sv
`default_nettype none
// tb_cordic_sched : directed vectors for cordic_sched; a queue scoreboard checks every result.
module tb_cordic_sched;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 32;
  localparam int IDW = 2;
  localparam int IFW = 6;
  localparam int TOL = 16;

  localparam logic [31:0] A_0  = 32'h0000_0000;
  localparam logic [31:0] A_P2 = 32'h0001_921F;
  localparam logic [31:0] A_M2 = 32'hFFFE_6DE1;
  localparam logic [31:0] A_PI = 32'h0003_243F;
  localparam logic [31:0] A_P6 = 32'h0000_860B;
  localparam logic [31:0] A_M6 = 32'hFFFF_79F5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [IDW-1:0] res_id;
  logic [W-1:0]   res_sin;
  logic [W-1:0]   res_cos;
  logic [IFW-1:0] inflight;
  logic           busy;
  logic [31:0]    ang [N];

  typedef struct { int id; int s; int c; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_res = 0;

  assign req_x = {ang[3], ang[2], ang[1], ang[0]};

  cordic_sched #(.N_REQ(4), .BITS_HIGH(16), .BITS_LOW(16), .LAT(32), .MAX_OUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .res_valid(res_valid), .res_id(res_id), .res_sin(res_sin), .res_cos(res_cos),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    n_chk++;
    if (act > exp + TOL || act < exp - TOL) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d +/- %0d (cycle %0d)", name, act, exp, TOL, cyc);
    end
  endtask

  // Hand-computed sine/cosine of the angle vectors, scaled by 65536
  function automatic exp_t mk(input int id, input logic [31:0] x, input int at);
    exp_t e;
    e.id = id; e.cyc = at; e.s = 0; e.c = 0;
    case (x)
      A_0:  begin e.s = 0;      e.c = 65536;  end
      A_P2: begin e.s = 65536;  e.c = 0;      end
      A_M2: begin e.s = -65536; e.c = 0;      end
      A_PI: begin e.s = 0;      e.c = -65536; end
      A_P6: begin e.s = 32768;  e.c = 56756;  end
      A_M6: begin e.s = -32768; e.c = 56756;  end
      default: begin e.s = 0;   e.c = 0;      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0)
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) sb.push_back(mk(i, ang[i], cyc + LAT));
  end

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      n_res++;
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", res_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("res_id", res_id, mon_e.id);
        chk("res_cycle", cyc, mon_e.cyc);
        chk_near("res_sin", $signed(res_sin), mon_e.s);
        chk_near("res_cos", $signed(res_cos), mon_e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_id"},    res_id,    0);
    chk({tag, "_res_sin"},   res_sin,   0);
    chk({tag, "_res_cos"},   res_cos,   0);
    chk({tag, "_inflight"},  inflight,  0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_drain"}, (busy || sb.size() != 0), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    rst       = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) ang[i] = A_0;
    step();
    step();
    req_valid = '1;
    @(negedge clk);
    chk("ready_in_reset", req_ready, 0);
    step();
    req_valid = '0;
    rst       = 1'b0;
    chk_reset_vals("reset");

    // Single request, inflight window
    step();
    ang[0]    = A_0;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", req_ready, 1);
    step();
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("single_inflight", inflight, 1);
      step();
    end
    @(negedge clk);
    chk("single_inflight_end", inflight, 0);
    chk("single_busy_end", busy, 0);
    step();

    // Quadrants, back to back from requester 1
    ang[1] = A_P2; req_valid = 4'b0010;
    @(negedge clk); chk("quad_ready0", req_ready, 2);
    step();
    ang[1] = A_M2;
    @(negedge clk); chk("quad_ready1", req_ready, 2);
    step();
    ang[1] = A_PI;
    @(negedge clk); chk("quad_ready2", req_ready, 2);
    step();
    req_valid = '0;
    wait_idle("quad");

    // Round robin with all requesters valid
    reset_dut();
    ang[0] = A_0; ang[1] = A_P6; ang[2] = A_M6; ang[3] = A_P2;
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_ready", req_ready, (1 << (k % 4)));
      step();
    end
    req_valid = '0;
    wait_idle("rr");

    // Credit limit on requester 2, bypass by requester 3, issue+retire overlap
    reset_dut();
    ang[2] = A_P6; ang[3] = A_0;
    for (int rel = 0; rel < 40; rel++) begin
      int e;
      req_valid = (rel == 10) ? 4'b1100 : 4'b0100;
      @(negedge clk);
      if (rel < 8 || rel >= 33) e = 4;
      else if (rel == 10)       e = 8;
      else                      e = 0;
      chk("credit_ready", req_ready, e);
      if (rel >= 33) chk("credit_inflight", inflight, 8);
      step();
    end
    req_valid = '0;
    wait_idle("credit");

    // Reset while ten transactions are in flight
    reset_dut();
    ang[0] = A_0; ang[1] = A_P2; ang[2] = A_PI; ang[3] = A_M6;
    n_before = n_res;
    for (int rel = 0; rel < 15; rel++) begin
      req_valid = (rel < 10) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      chk("flight_ready", req_ready, (rel < 10) ? (1 << (rel % 4)) : 0);
      step();
    end
    rst       = 1'b1;
    req_valid = 4'b1111;
    sb.delete();
    @(negedge clk);
    chk("flight_ready_in_reset", req_ready, 0);
    step();
    rst       = 1'b0;
    req_valid = '0;
    chk_reset_vals("flight_reset");
    for (int k = 0; k < LAT + 8; k++) step();
    chk("flight_no_results", n_res, n_before);

    req_valid = 4'b1000;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 8);
    step();
    req_valid = '0;
    wait_idle("post_reset");
    chk("post_reset_results", n_res, n_before + 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
